// File: rtl/imem_loader_pkg.sv
// Shared types and derivations for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_FILL,
        S_ERROR
    } state_t;

    // The first byte received is the most significant byte of the word.
    localparam bit BIG_ENDIAN = 1'b1;

    function automatic int bytes_of(input int n);
        return n / 8;
    endfunction

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles bytes into an N-bit word; word_valid flags the transfer completing a word.
// Zero latency on word_valid, word register updates on the accepting edge; no backpressure of its own.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         in_vld,
    input  logic [7:0]   in_dat,
    output logic         word_valid,
    output logic [N-1:0] word
);

    localparam int BYTES = bytes_of(N);
    localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (in_vld) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            if (BIG_ENDIAN)
                r_word <= (r_word << 8) | N'(in_dat);
            else
                r_word <= (r_word >> 8) | (N'(in_dat) << (N - 8));
        end
    end

    assign word_valid = in_vld && (r_cnt == LAST);
    assign word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a byte stream, zero-fills the rest and holds the core in reset meanwhile.
// One write per word the cycle after its last byte; byte_ready is decoded from state only.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N             = 32,
    parameter int ADDR_W        = 6,
    parameter int TIMEOUT       = 1024,
    parameter bit HOLD_AT_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = depth_of(ADDR_W);
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT - 1);

    state_t          r_state, w_next;
    logic [ADDR_W:0] r_len, r_idx, w_idx_inc, w_len_clamped;
    logic [TW-1:0]   r_idle;
    logic            r_loaded, r_done;
    logic            w_start_ok, w_xfer, w_word_vld, w_finish, w_timeout;
    logic [N-1:0]    w_word;

    assign w_xfer        = byte_valid && (r_state == S_LOAD);
    assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_ERROR));
    assign w_len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
    assign w_idx_inc     = r_idx + 1'b1;
    assign w_timeout     = !byte_valid && (r_idle == TO_LAST);

    byte_packer #(.N(N)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_start_ok),
        .in_vld     (w_xfer),
        .in_dat     (byte_data),
        .word_valid (w_word_vld),
        .word       (w_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_finish   = 1'b0;
        byte_ready = 1'b0;
        we         = 1'b0;
        waddr      = '0;
        wdata      = '0;
        busy       = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                err = (r_state == S_ERROR);
                if (w_start_ok)
                    w_next = (w_len_clamped == '0) ? S_FILL : S_LOAD;
            end
            S_LOAD: begin
                busy       = 1'b1;
                byte_ready = 1'b1;
                if (w_word_vld)     w_next = S_WRITE;
                else if (w_timeout) w_next = S_ERROR;
            end
            S_WRITE: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = r_idx[ADDR_W-1:0];
                wdata = w_word;
                if (w_idx_inc == r_len) begin
                    // A full-depth load leaves nothing to zero-fill.
                    if (r_len == DEPTH_C) begin
                        w_next   = S_IDLE;
                        w_finish = 1'b1;
                    end else begin
                        w_next = S_FILL;
                    end
                end else begin
                    w_next = S_LOAD;
                end
            end
            S_FILL: begin
                busy  = 1'b1;
                we    = 1'b1;
                waddr = r_idx[ADDR_W-1:0];
                if (r_idx == LAST_ADDR) begin
                    w_next   = S_IDLE;
                    w_finish = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len    <= '0;
            r_idx    <= '0;
            r_idle   <= '0;
            r_loaded <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish)
                r_loaded <= 1'b1;
            if (w_start_ok) begin
                r_len <= w_len_clamped;
                r_idx <= '0;
            end else if ((r_state == S_WRITE) || (r_state == S_FILL)) begin
                r_idx <= w_idx_inc;
            end
            if ((r_state != S_LOAD) || w_xfer)
                r_idle <= '0;
            else
                r_idle <= r_idle + 1'b1;
        end
    end

    assign cpu_reset = (r_state != S_IDLE) || (HOLD_AT_RESET && !r_loaded);
    assign done      = r_done;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a memory-image reference model.
module tb_imem_loader;

    localparam int N = 32, AW = 6, DEPTH = 64, BYTES = 4, TIMEOUT = 1024;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [AW:0]   len = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready, we, cpu_reset, busy, done, err;
    logic [AW-1:0] waddr;
    logic [N-1:0]  wdata;

    imem_loader #(.N(N), .ADDR_W(AW), .TIMEOUT(TIMEOUT), .HOLD_AT_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .cpu_reset(cpu_reset),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    logic [7:0]  stream[$];
    logic [31:0] obs_mem[DEPTH];
    int          obs_cnt[DEPTH];
    int cyc = 0, done_cnt, done_cyc, last_we_cyc, busy_cyc;
    bit rdy_seen, done_cpurst, bad_cpurst;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (we) begin
                obs_mem[waddr] = wdata;
                obs_cnt[waddr]++;
                last_we_cyc = cyc;
            end
            if (busy) busy_cyc++;
            if (busy && !cpu_reset) bad_cpurst = 1'b1;
            if (byte_ready) rdy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                done_cpurst = cpu_reset;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        for (int a = 0; a < DEPTH; a++) begin
            obs_mem[a] = '0;
            obs_cnt[a] = 0;
        end
        done_cnt = 0; done_cyc = 0; last_we_cyc = 0; busy_cyc = 0;
        rdy_seen = 1'b0; done_cpurst = 1'b1; bad_cpurst = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b);
        int g;
        byte_data  = b;
        byte_valid = 1'b1;
        g = 0;
        while (!byte_ready && g < 50) begin tick(); g++; end
        if (g >= 50) chk({tag, "_rdy_wait"}, byte_ready, 1);
        tick();
    endtask

    task automatic fill_random(input int nbytes);
        stream.delete();
        for (int i = 0; i < nbytes; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [31:0] model_word(input int idx, input int nwords);
        if (idx >= nwords) return 32'h0;
        return {stream[4*idx], stream[4*idx+1], stream[4*idx+2], stream[4*idx+3]};
    endfunction

    task automatic run_load(input string tag, input int len_in, input bit gappy);
        int L, g;
        L = (len_in > DEPTH) ? DEPTH : len_in;
        clear_obs();
        len   = AW'(0) | (AW+1)'(len_in);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < L * BYTES; i++) begin
            if (gappy) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            send_byte(tag, stream[i]);
        end
        byte_valid = 1'b0;
        g = 0;
        while (done_cnt == 0 && g < 300) begin tick(); g++; end
        tick(); tick();
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_after_last_we"}, done_cyc, last_we_cyc + 1);
        chk({tag, "_cpurst_at_done"}, done_cpurst, 0);
        chk({tag, "_cpurst_low_while_busy"}, bad_cpurst, 0);
        if (!gappy) chk({tag, "_busy_cycles"}, busy_cyc, L * (BYTES + 1) + (DEPTH - L));
        if (L == 0) chk({tag, "_rdy_seen"}, rdy_seen, 0);
        for (int a = 0; a < DEPTH; a++) begin
            chk($sformatf("%s_mem%0d", tag, a), obs_mem[a], model_word(a, L));
            chk($sformatf("%s_wcnt%0d", tag, a), obs_cnt[a], 1);
        end
        chk({tag, "_err_after"}, err, 0);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_cpurst_after"}, cpu_reset, 0);
    endtask

    initial begin
        int k;
        bit hit;
        logic [31:0] expw;

        clear_obs();
        repeat (2) @(negedge clk);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_reset", cpu_reset, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        chk("idle_hold_cpu_reset", cpu_reset, 1);

        stream = {8'hF8, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h80, 8'h01,
                  8'hCB, 8'h0E, 8'h01, 8'hCE};
        run_load("full3", 3, 1'b0);
        chk("full3_word0", obs_mem[0], 32'hF800_0000);
        chk("full3_word1", obs_mem[1], 32'hF800_8001);
        chk("full3_word2", obs_mem[2], 32'hCB0E_01CE);

        run_load("len0", 0, 1'b0);

        fill_random(DEPTH * BYTES);
        run_load("len100", 100, 1'b0);

        stream = {8'hF8, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h80, 8'h01,
                  8'hCB, 8'h0E, 8'h01, 8'hCE};
        run_load("gap3", 3, 1'b1);
        fill_random(20 * BYTES);
        run_load("gap20", 20, 1'b1);

        fill_random(6);
        len   = 7'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte("to", stream[i]);
        byte_valid = 1'b0;
        k   = 0;
        hit = 1'b0;
        while (!hit && k < TIMEOUT + 20) begin
            if (k == TIMEOUT - 1) begin start = 1'b1; len = 7'd1; end
            tick();
            start = 1'b0;
            k++;
            if (err) hit = 1'b1;
        end
        chk("to_idle_cycles", k, TIMEOUT);
        chk("to_err", err, 1);
        chk("to_cpu_reset", cpu_reset, 1);
        chk("to_busy", busy, 0);
        chk("to_byte_ready", byte_ready, 0);
        tick();
        chk("to_err_held", err, 1);

        fill_random(BYTES);
        run_load("recover", 1, 1'b0);

        fill_random(2 * BYTES);
        expw  = {stream[0], stream[1], stream[2], stream[3]};
        len   = 7'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte("mw", stream[0]);
        start = 1'b1;
        len   = 7'd0;
        send_byte("mw", stream[1]);
        start = 1'b0;
        send_byte("mw", stream[2]);
        send_byte("mw", stream[3]);
        byte_valid = 1'b0;
        chk("mw_we", we, 1);
        chk("mw_waddr", waddr, 0);
        chk("mw_wdata", wdata, expw);
        #1 reset = 1'b1;
        #1;
        chk("mw_rst_we", we, 0);
        chk("mw_rst_waddr", waddr, 0);
        chk("mw_rst_wdata", wdata, 0);
        chk("mw_rst_busy", busy, 0);
        chk("mw_rst_done", done, 0);
        chk("mw_rst_err", err, 0);
        chk("mw_rst_byte_ready", byte_ready, 0);
        chk("mw_rst_cpu_reset", cpu_reset, 1);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("mw_post_busy", busy, 0);
        chk("mw_post_cpu_reset", cpu_reset, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
